// File: rtl/window3x3_generator.sv
// Sliding 3x3 neighbourhood generator for a raster-order pixel stream.
// Two row line buffers feed a 3x3 column shift register; one window per accepted pixel.
module window3x3_generator #(
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned IMG_HEIGHT = 240,
  parameter int unsigned PIX_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_start,
  input  logic                          pix_valid,
  input  logic [PIX_W-1:0]              pix_data,
  output logic [9*PIX_W-1:0]            window,
  output logic                          win_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_y,
  output logic                          frame_overrun
);

  localparam int unsigned XW = $clog2(IMG_WIDTH);
  localparam int unsigned YW = $clog2(IMG_HEIGHT);
  localparam int unsigned WW = 9 * PIX_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [WW-1:0]   sr_q, sr_d;
  logic [WW-1:0]   window_q, window_d;
  logic            win_valid_q, win_valid_d;
  logic [XW-1:0]   win_x_q, win_x_d;
  logic [YW-1:0]   win_y_q, win_y_d;
  logic            overrun_q, overrun_d;

  logic [XW-1:0]   cur_x_c;
  logic [YW-1:0]   cur_y_c;
  logic            accept_c;
  logic [PIX_W-1:0] lb0_rd_c;
  logic [PIX_W-1:0] lb1_rd_c;

  logic [PIX_W-1:0] line0_q [IMG_WIDTH];
  logic [PIX_W-1:0] line1_q [IMG_WIDTH];

  // A frame_start pulse re-bases the pixel arriving in the same cycle to (0,0).
  assign cur_x_c  = frame_start ? '0 : x_q;
  assign cur_y_c  = frame_start ? '0 : y_q;
  assign accept_c = pix_valid && (frame_start || (state_q == S_ACTIVE));
  assign lb0_rd_c = line0_q[cur_x_c];
  assign lb1_rd_c = line1_q[cur_x_c];

  // Read-before-write line buffers: line1 holds row y-1, line0 holds row y-2.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      line0_q[cur_x_c] <= lb1_rd_c;
      line1_q[cur_x_c] <= pix_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    sr_d        = sr_q;
    window_d    = window_q;
    win_valid_d = 1'b0;
    win_x_d     = win_x_q;
    win_y_d     = win_y_q;
    overrun_d   = overrun_q;

    if (frame_start) begin
      state_d   = S_ACTIVE;
      x_d       = '0;
      y_d       = '0;
      overrun_d = 1'b0;
    end else if (pix_valid && (state_q == S_DONE)) begin
      overrun_d = 1'b1;
    end

    if (accept_c) begin
      for (int r = 0; r < 3; r++) begin
        sr_d[PIX_W*(3*r)   +: PIX_W] = sr_q[PIX_W*(3*r+1) +: PIX_W];
        sr_d[PIX_W*(3*r+1) +: PIX_W] = sr_q[PIX_W*(3*r+2) +: PIX_W];
      end
      sr_d[PIX_W*2 +: PIX_W] = lb0_rd_c;
      sr_d[PIX_W*5 +: PIX_W] = lb1_rd_c;
      sr_d[PIX_W*8 +: PIX_W] = pix_data;

      // Border and row-wrap windows are suppressed by the x/y >= 2 gate.
      if ((cur_x_c >= XW'(2)) && (cur_y_c >= YW'(2))) begin
        win_valid_d = 1'b1;
        window_d    = sr_d;
        win_x_d     = cur_x_c - XW'(1);
        win_y_d     = cur_y_c - YW'(1);
      end

      if (cur_x_c == XW'(IMG_WIDTH - 1)) begin
        x_d = '0;
        if (cur_y_c == YW'(IMG_HEIGHT - 1)) begin
          state_d = S_DONE;
          y_d     = '0;
        end else begin
          y_d = cur_y_c + YW'(1);
        end
      end else begin
        x_d = cur_x_c + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      sr_q        <= '0;
      window_q    <= '0;
      win_valid_q <= 1'b0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sr_q        <= sr_d;
      window_q    <= window_d;
      win_valid_q <= win_valid_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
      overrun_q   <= overrun_d;
    end
  end

  assign window        = window_q;
  assign win_valid     = win_valid_q;
  assign win_x         = win_x_q;
  assign win_y         = win_y_q;
  assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_window3x3_generator.sv
// Bench for window3x3_generator: a 4x4 and an 8x6 instance share one stimulus stream and
// are checked cycle by cycle against a frame-image reference model.
module tb_window3x3_generator;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         frame_start;
  logic         pix_valid;
  logic [15:0]  pix_data;

  logic [143:0] win4, win8;
  logic         wv4, wv8;
  logic [1:0]   wx4, wy4;
  logic [2:0]   wx8, wy8;
  logic         ovr4, ovr8;

  always #5 clk = ~clk;

  window3x3_generator #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .PIX_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_data(pix_data), .window(win4), .win_valid(wv4), .win_x(wx4), .win_y(wy4),
    .frame_overrun(ovr4)
  );

  window3x3_generator #(.IMG_WIDTH(8), .IMG_HEIGHT(6), .PIX_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_data(pix_data), .window(win8), .win_valid(wv8), .win_x(wx8), .win_y(wy8),
    .frame_overrun(ovr8)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: 0 idle, 1 active, 2 done; windows cut straight out of the frame image.
  int           m_st [2];
  int           m_x  [2];
  int           m_y  [2];
  logic         m_valid [2];
  logic         m_ovr [2];
  int           m_wx [2];
  int           m_wy [2];
  logic [143:0] m_win [2];
  logic [15:0]  img [2][6][8];

  int           win_cnt [2];
  logic [143:0] first_win;
  logic [143:0] last_win;
  int           first_x, first_y, last_x, last_y;

  function automatic void model_reset();
    for (int id = 0; id < 2; id++) begin
      m_st[id] = 0; m_x[id] = 0; m_y[id] = 0;
      m_valid[id] = 1'b0; m_ovr[id] = 1'b0;
      m_wx[id] = 0; m_wy[id] = 0; m_win[id] = '0;
    end
  endfunction

  function automatic void model_step(int id, logic fs, logic pv, logic [15:0] d);
    int w = (id == 0) ? 4 : 8;
    int h = (id == 0) ? 4 : 6;
    m_valid[id] = 1'b0;
    if (fs) begin
      m_st[id] = 1; m_x[id] = 0; m_y[id] = 0; m_ovr[id] = 1'b0;
    end
    if (pv) begin
      if (m_st[id] == 1) begin
        img[id][m_y[id]][m_x[id]] = d;
        if (m_x[id] >= 2 && m_y[id] >= 2) begin
          m_valid[id] = 1'b1;
          m_wx[id] = m_x[id] - 1;
          m_wy[id] = m_y[id] - 1;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              m_win[id][16*(3*r+c) +: 16] = img[id][m_y[id]-2+r][m_x[id]-2+c];
        end
        if (m_x[id] == w - 1) begin
          m_x[id] = 0;
          if (m_y[id] == h - 1) m_st[id] = 2;
          else m_y[id]++;
        end else begin
          m_x[id]++;
        end
      end else if (m_st[id] == 2) begin
        m_ovr[id] = 1'b1;
      end
    end
  endfunction

  task automatic compare_outputs();
    check("wv4",  144'(wv4),  144'(m_valid[0]));
    check("ovr4", 144'(ovr4), 144'(m_ovr[0]));
    check("win4", win4, m_win[0]);
    if (m_valid[0]) begin
      check("wx4", 144'(wx4), 144'(m_wx[0]));
      check("wy4", 144'(wy4), 144'(m_wy[0]));
    end
    check("wv8",  144'(wv8),  144'(m_valid[1]));
    check("ovr8", 144'(ovr8), 144'(m_ovr[1]));
    check("win8", win8, m_win[1]);
    if (m_valid[1]) begin
      check("wx8", 144'(wx8), 144'(m_wx[1]));
      check("wy8", 144'(wy8), 144'(m_wy[1]));
    end
    if (wv4) begin
      if (win_cnt[0] == 0) begin
        first_win = win4; first_x = int'(wx4); first_y = int'(wy4);
      end
      last_win = win4; last_x = int'(wx4); last_y = int'(wy4);
      win_cnt[0]++;
    end
    if (wv8) win_cnt[1]++;
  endtask

  task automatic step(input logic fs, input logic pv, input logic [15:0] d);
    @(negedge clk);
    compare_outputs();
    frame_start = fs;
    pix_valid   = pv;
    pix_data    = d;
    model_step(0, fs, pv, d);
    model_step(1, fs, pv, d);
  endtask

  task automatic send_frame4(input logic [7:0] hi, input logic fs_first);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        step(fs_first && x == 0 && y == 0, 1'b1, {hi, 4'(y), 4'(x)});
  endtask

  function automatic logic [143:0] grid(logic [7:0] hi, int y0, int x0);
    logic [143:0] g;
    g = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        g[16*(3*r+c) +: 16] = {hi, 4'(y0 + r), 4'(x0 + c)};
    return g;
  endfunction

  logic [15:0] frame8 [48];

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    model_reset();
    win_cnt[0] = 0; win_cnt[1] = 0;
    first_win = '0; last_win = '0;
    first_x = 0; first_y = 0; last_x = 0; last_y = 0;
    repeat (2) @(negedge clk);
    check("rst_win4", win4, '0);
    check("rst_ovr4", 144'(ovr4), '0);
    rst_n = 1'b1;

    // Reset in the middle of a frame.
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'($urandom));
    step(1'b0, 1'b0, '0);
    @(negedge clk);
    compare_outputs();
    rst_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check("mrst_wv4", 144'(wv4), '0);
      check("mrst_wx4", 144'({wy4, wx4}), '0);
      check("mrst_ovr", 144'({ovr4, ovr8}), '0);
      check("mrst_win8", win8, '0);
    end
    rst_n = 1'b1;
    win_cnt[0] = 0; win_cnt[1] = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 16'($urandom));
    step(1'b0, 1'b0, '0);
    check("idle_cnt", 144'(win_cnt[0] + win_cnt[1]), '0);

    // Gap-free 4x4 frame with pixel = 00YX.
    win_cnt[0] = 0;
    step(1'b1, 1'b0, '0);
    send_frame4(8'h00, 1'b0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check("cnt4", 144'(win_cnt[0]), 144'(4));
    check("first_win", first_win, grid(8'h00, 0, 0));
    check("first_xy", 144'({first_y, first_x}), 144'({32'd1, 32'd1}));
    check("last_xy", 144'({last_y, last_x}), 144'({32'd2, 32'd2}));
    check("last_ctr", 144'(last_win[16*4 +: 16]), 144'(16'h0022));
    check("last_e8", 144'(last_win[16*8 +: 16]), 144'(16'h0033));

    // Pixel after frame end, then frame_start coincident with pixel (0,0).
    step(1'b0, 1'b1, 16'hBEEF);
    step(1'b0, 1'b0, '0);
    check("ovr_set", 144'(ovr4), 144'(1));
    check("ovr_nowin", 144'(wv4), '0);
    win_cnt[0] = 0;
    step(1'b1, 1'b1, 16'h0100);
    step(1'b0, 1'b0, '0);
    check("ovr_clr", 144'(ovr4), '0);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        if (x != 0 || y != 0) step(1'b0, 1'b1, {8'h01, 4'(y), 4'(x)});
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check("cnt4_fs", 144'(win_cnt[0]), 144'(4));
    check("fs_first", first_win, grid(8'h01, 0, 0));

    // Restart after 1.5 rows, then a full frame of new data.
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, {8'h0A, 4'(i / 4), 4'(i % 4)});
    win_cnt[0] = 0;
    send_frame4(8'h02, 1'b1);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check("cnt4_rs", 144'(win_cnt[0]), 144'(4));
    check("rs_first", first_win, grid(8'h02, 0, 0));
    check("rs_xy", 144'({first_y, first_x}), 144'({32'd1, 32'd1}));

    // 8x6 random frame, gap-free then with random 0-3 cycle gaps.
    for (int i = 0; i < 48; i++) frame8[i] = 16'($urandom);
    win_cnt[1] = 0;
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 48; i++) step(1'b0, 1'b1, frame8[i]);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check("cnt8", 144'(win_cnt[1]), 144'(24));
    win_cnt[1] = 0;
    for (int i = 0; i < 48; i++) begin
      step(i == 0, 1'b1, frame8[i]);
      repeat ($urandom_range(3, 0)) step(1'b0, 1'b0, 16'($urandom));
    end
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check("cnt8_gap", 144'(win_cnt[1]), 144'(24));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
